opt2ws_gemm_ctrl: RTL and testbench
===================================

# opt2ws_gemm_ctrl

Sequencer for the output-stationary-free, weight-stationary TPE array. It handles one GEMM tile A[m,K]·B[K,N] at a time:
- loads the K weight rows of B into the array;
- streams up to M_MAX rows of A from an upstream buffer;
- regenerates the per-column skewed result-valid strobes and row indices that the result collector needs.

It sits between the operand buffers and the array's `operand_a` / `weight_wen` / `weight_din` / `data_valid` inputs.

## Interface
Parameters:
- `N`, 16: array columns (output width of one A row).
- `K`, 16: reduction depth. It equals both the weight rows per load and the int8 lanes of `a_data`.
- `M_MAX`, 32: maximum rows of A per tile.
- `LAT`, 8: cycles from `data_valid` high to the column-0 result being valid.
- `CM`, `$clog2(M_MAX)`: row-index width (localparam).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset. One clock domain; `rst` is asynchronous and active-high.
- `start`  in  1  one-cycle tile start. Ignored unless `busy`=0.
- `load_w`  in  1  sampled with `start`. 1 means reload the weights first; 0 means reuse the resident weights.
- `m_rows`  in  CM+1  rows of A for this tile, sampled with `start`.
- `abort`  in  1  synchronous cancel.
- `w_valid`/`w_ready`  in/out  1/1  weight-row handshake.
- `w_data`  in  8*N  one row of B. Lane j holds B[k][j].
- `a_valid`/`a_ready`  in/out  1/1  A-row handshake.
- `a_data`  in  8*K  one row of A. Lane k holds A[r][k].
- `weight_wen`  out  1  to the array.
- `weight_din`  out  8*N  to the array.
- `operand_a`  out  8*K  to the array.
- `data_valid`  out  1  to the array.
- `col_valid`  out  N  bit i high when the array's column i result for row `col_row[i]` is on the bus.
- `col_row`  out  CM*N  row index per column.
- `busy`  out  1  controller is not in IDLE.
- `done`  out  1  one-cycle tile-complete pulse.

## Operation
States: IDLE, LOAD_W, STREAM_A, DRAIN, DONE.

- **IDLE**
  - On `start`, latch `load_w` and `m_rows`. Clamp `m_rows` to M_MAX.
  - Next state is LOAD_W if `load_w`=1, otherwise STREAM_A.
  - `start` with `load_w`=0 and `m_rows`=0 goes straight to DONE.
- **LOAD_W**
  - `w_ready`=1.
  - Each `w_valid & w_ready` registers `weight_wen`=1 and `weight_din`=`w_data` for exactly the next cycle. The row counter wk increments.
  - When wk reaches K, go to STREAM_A, or to DONE if `m_rows`=0 (weight preload only).
  - While `w_valid`=0, `weight_wen`=0 and `weight_din`=0.
- **STREAM_A**
  - `a_ready`=1 while the row counter ar < `m_rows`.
  - Each handshake registers `operand_a`=`a_data` and `data_valid`=1 for the next cycle.
  - Bubbles (`a_valid`=0) give `data_valid`=0 and `operand_a`=0.
  - After the `m_rows`-th handshake, go to DRAIN.
- **DRAIN**
  - Wait until the internal valid delay line (LAT+N-1 deep) is all zero and `col_valid`=0.
  - Then go to DONE.
- **DONE**
  - `done`=1 for one cycle, then IDLE.

Result tracking:
- `col_valid[0]` is `data_valid` delayed LAT cycles. `col_valid[i]` is `col_valid[i-1]` delayed 1 cycle.
- Each column has a CM-bit counter that increments on its own `col_valid[i]`. `col_row[i]` shows the counter value during the valid cycle.
- A column counter wraps to 0 after row `m_rows`-1 and is cleared on entry to STREAM_A.
- Bubbles in the input stream do not advance the counters.

`abort`:
- Takes effect from any state and sends the FSM to IDLE next cycle with no `done` pulse.
- Clears `weight_wen`, `data_valid`, the delay line, `col_valid` and all counters.
- Weights already written are left resident.

## Timing
- Reset values: `w_ready`=0, `a_ready`=0, `weight_wen`=0, `weight_din`=0, `operand_a`=0, `data_valid`=0, `col_valid`=0, `col_row`=0, `busy`=0, `done`=0. State is IDLE and all counters are 0.
- `rst` asserted mid-tile gives the same values immediately (asynchronous). The upstream must re-issue `start`.
- `start` at cycle t gives `busy`=1 at t+1 and `w_ready` or `a_ready`=1 at t+1. All outputs are registered.
- A handshake at cycle t drives `weight_wen`, `data_valid` and operands at t+1.
- Throughput is one weight row or one A row per cycle with no gaps. K back-to-back weight rows take K cycles.
- For a `data_valid` at cycle d:
  - `col_valid[i]` is high at d+LAT+i.
  - For the last row at d, `col_valid[N-1]` is high at d+LAT+N-1.
  - `done` is high at d+LAT+N. `busy` falls at d+LAT+N+1.
- `start` while `busy`=1 is ignored. `start` in the same cycle as `done` is ignored.
- `abort` and a handshake in the same cycle: `abort` wins and the handshake's data is discarded.

## Test plan
- **Reload and stream:** `load_w`=1, `m_rows`=32, K=16 back-to-back weight rows, then 32 back-to-back A rows.
  - `weight_wen` is high for 16 consecutive cycles.
  - `data_valid` is high for 32 cycles starting at d0.
  - `col_valid[15]` first rises at d0+23.
  - `done` pulses at d0+31+24.
  - All 32×16 results match the integer GEMM.
- **Reuse weights:** `load_w`=0, `m_rows`=5.
  - No `weight_wen` pulses.
  - `a_ready` is high at t+1.
  - `col_row[0]` takes the values 0..4 on its five valid cycles.
  - `done` pulses at d_last+24.
- **Bubbles:** `m_rows`=4, `a_valid` pattern 1,0,0,1,1,0,1.
  - `data_valid` shows the same gaps.
  - Column counters count only valid cycles, giving rows 0..3.
  - `done` follows the last valid by LAT+N cycles.
- **Edge counts:**
  - `m_rows`=0 with `load_w`=1: 16 weight rows, then `done`, no `data_valid`.
  - `m_rows`=40: clamped to 32, exactly 32 `a_ready` handshakes.
- **Abort and reset:**
  - `abort` in STREAM_A after row 10: IDLE next cycle, `data_valid` and `col_valid`=0, no `done`.
  - Async `rst` pulse mid-DRAIN: all outputs 0 immediately.
  - A subsequent tile with `m_rows`=32 completes correctly.
- **Start while busy:** `start` pulses during LOAD_W and during the DONE cycle are ignored, and `m_rows` stays as originally latched.

Source files
------------

// File: rtl/opt2ws_gemm_ctrl.sv
// Tile sequencer for the weight-stationary TPE array: weight-row preload, A-row streaming
// and regeneration of the skewed per-column result-valid strobes and row indices.
module opt2ws_gemm_ctrl #(
  parameter int N     = 16,
  parameter int K     = 16,
  parameter int M_MAX = 32,
  parameter int LAT   = 8,
  localparam int CM   = $clog2(M_MAX)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            load_w,
  input  logic [CM:0]     m_rows,
  input  logic            abort,
  input  logic            w_valid,
  output logic            w_ready,
  input  logic [8*N-1:0]  w_data,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [8*K-1:0]  a_data,
  output logic            weight_wen,
  output logic [8*N-1:0]  weight_din,
  output logic [8*K-1:0]  operand_a,
  output logic            data_valid,
  output logic [N-1:0]    col_valid,
  output logic [CM*N-1:0] col_row,
  output logic            busy,
  output logic            done
);

  localparam int DL  = LAT + N - 1;
  localparam int MW  = CM + 1;
  localparam int WKW = $clog2(K + 1);
  localparam logic [MW-1:0] M_MAX_V = MW'(M_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM_A,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [MW-1:0]    m_rows_q, m_rows_d;
  logic [WKW-1:0]   wk_q, wk_d;
  logic [MW-1:0]    ar_q, ar_d;
  logic             w_ready_q, a_ready_q, busy_q, done_q;
  logic             weight_wen_q, data_valid_q;
  logic [8*N-1:0]   weight_din_q;
  logic [8*K-1:0]   operand_a_q;
  logic [DL-1:0]    pipe_q;
  logic [CM-1:0]    cnt_q [N];
  logic             w_hs, a_hs, clr_cols;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    m_rows_d = m_rows_q;
    wk_d     = wk_q;
    ar_d     = ar_q;
    w_hs     = w_valid & w_ready_q & (state_q == S_LOAD_W);
    a_hs     = a_valid & a_ready_q & (state_q == S_STREAM_A);
    clr_cols = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          m_rows_d = (m_rows > M_MAX_V) ? M_MAX_V : m_rows;
          wk_d     = '0;
          ar_d     = '0;
          if (load_w)            state_d = S_LOAD_W;
          else if (m_rows == '0) state_d = S_DONE;
          else                   state_d = S_STREAM_A;
        end
      end
      S_LOAD_W: begin
        if (w_hs) begin
          wk_d = wk_q + WKW'(1);
          if (wk_q == WKW'(K - 1)) state_d = (m_rows_q == '0) ? S_DONE : S_STREAM_A;
        end
      end
      S_STREAM_A: begin
        if (a_hs) begin
          ar_d = ar_q + MW'(1);
          if (ar_d == m_rows_q) state_d = S_DRAIN;
        end
      end
      // Leave one cycle early so DONE coincides with the delay line becoming empty.
      S_DRAIN: begin
        if (!data_valid_q && (pipe_q[DL-2:0] == '0)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if ((state_d == S_STREAM_A) && (state_q != S_STREAM_A)) begin
      ar_d     = '0;
      clr_cols = 1'b1;
    end

    if (abort) begin
      state_d  = S_IDLE;
      wk_d     = '0;
      ar_d     = '0;
      clr_cols = 1'b1;
      w_hs     = 1'b0;
      a_hs     = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      m_rows_q     <= '0;
      wk_q         <= '0;
      ar_q         <= '0;
      w_ready_q    <= 1'b0;
      a_ready_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      weight_wen_q <= 1'b0;
      weight_din_q <= '0;
      data_valid_q <= 1'b0;
      operand_a_q  <= '0;
      pipe_q       <= '0;
    end else begin
      state_q      <= state_d;
      m_rows_q     <= m_rows_d;
      wk_q         <= wk_d;
      ar_q         <= ar_d;
      w_ready_q    <= (state_d == S_LOAD_W);
      a_ready_q    <= (state_d == S_STREAM_A) && (ar_d < m_rows_d);
      busy_q       <= (state_d != S_IDLE);
      done_q       <= (state_d == S_DONE);
      weight_wen_q <= w_hs;
      weight_din_q <= w_hs ? w_data : '0;
      data_valid_q <= a_hs;
      operand_a_q  <= a_hs ? a_data : '0;
      pipe_q       <= abort ? '0 : {pipe_q[DL-2:0], data_valid_q};
    end
  end

  // NOTE: the per-column row counters are a small flop array, so they are reset like any other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (clr_cols) begin
          cnt_q[i] <= '0;
        end else if (pipe_q[LAT-1+i]) begin
          cnt_q[i] <= ({1'b0, cnt_q[i]} == (m_rows_q - MW'(1))) ? '0 : cnt_q[i] + CM'(1);
        end
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    assign col_row[i*CM +: CM] = cnt_q[i];
  end

  assign col_valid  = pipe_q[DL-1:LAT-1];
  assign w_ready    = w_ready_q;
  assign a_ready    = a_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign weight_wen = weight_wen_q;
  assign weight_din = weight_din_q;
  assign data_valid = data_valid_q;
  assign operand_a  = operand_a_q;

endmodule

// File: tb/tb_opt2ws_gemm_ctrl.sv
// Randomized bench for opt2ws_gemm_ctrl: a cycle-indexed schedule of expected outputs is built
// from the handshake rules and compared every cycle, plus per-scenario summary checks.
module tb_opt2ws_gemm_ctrl;

  localparam int N     = 16;
  localparam int K     = 16;
  localparam int M_MAX = 32;
  localparam int LAT   = 8;
  localparam int CM    = $clog2(M_MAX);
  localparam int MW    = CM + 1;
  localparam int MAXC  = 512;

  logic            clk;
  logic            rst;
  logic            start;
  logic            load_w;
  logic [CM:0]     m_rows;
  logic            abort;
  logic            w_valid;
  logic            w_ready;
  logic [8*N-1:0]  w_data;
  logic            a_valid;
  logic            a_ready;
  logic [8*K-1:0]  a_data;
  logic            weight_wen;
  logic [8*N-1:0]  weight_din;
  logic [8*K-1:0]  operand_a;
  logic            data_valid;
  logic [N-1:0]    col_valid;
  logic [CM*N-1:0] col_row;
  logic            busy;
  logic            done;

  opt2ws_gemm_ctrl #(.N(N), .K(K), .M_MAX(M_MAX), .LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .load_w     (load_w),
    .m_rows     (m_rows),
    .abort      (abort),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_data     (w_data),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_data     (a_data),
    .weight_wen (weight_wen),
    .weight_din (weight_din),
    .operand_a  (operand_a),
    .data_valid (data_valid),
    .col_valid  (col_valid),
    .col_row    (col_row),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Per-tile observations of the DUT, checked by the scenario tasks.
  int st_wen, st_dv, st_ahs, st_done_c;
  int st_col0_rows[$];

  // Expected output schedule, indexed by cycle relative to the start pulse.
  logic            exp_wen  [MAXC];
  logic [8*N-1:0]  exp_wdin [MAXC];
  logic            exp_dv   [MAXC];
  logic [8*K-1:0]  exp_op   [MAXC];
  logic [N-1:0]    exp_cv   [MAXC];
  logic [CM*N-1:0] exp_cr   [MAXC];

  task automatic run_tile(input logic lw, input int mr, input int wprob, input int aprob,
                          input logic [31:0] apat, input int apat_len, input int abort_rows,
                          input bit rst_drain, input bit busy_starts, input string name);
    int m_eff, wk, ar, a_ph, done_c, abort_at, rst_at, rowi;
    bit aborted, ew_rdy, ea_rdy, e_busy, e_done;
    logic [N-1:0]    e_cv;
    logic [CM*N-1:0] act_cr, e_cr;
    for (int c = 0; c < MAXC; c++) begin
      exp_wen[c] = 1'b0; exp_wdin[c] = '0; exp_dv[c] = 1'b0;
      exp_op[c]  = '0;   exp_cv[c]   = '0; exp_cr[c] = '0;
    end
    m_eff = (mr > M_MAX) ? M_MAX : mr;
    wk = 0; ar = 0; a_ph = 0; rowi = 0;
    done_c = -1; abort_at = -1; rst_at = -1;
    if (!lw && m_eff == 0) done_c = 1;
    st_wen = 0; st_dv = 0; st_ahs = 0; st_done_c = -1;
    st_col0_rows.delete();

    for (int c = 0; c < MAXC - LAT - N - 4; c++) begin
      @(posedge clk); #1;
      aborted = (abort_at >= 0) && (c > abort_at);
      ew_rdy  = 1'b0;
      ea_rdy  = 1'b0;
      if (c >= 1) begin
        ew_rdy = !aborted && lw && (wk < K);
        ea_rdy = !aborted && (!lw || wk == K) && (ar < m_eff);
        e_busy = !aborted && (done_c < 0 || c <= done_c);
        e_done = !aborted && (c == done_c);
        e_cv   = aborted ? '0 : exp_cv[c];
        checks++; if (w_ready !== ew_rdy) begin failures++;
          $display("FAIL %s w_ready c=%0d got=%b exp=%b", name, c, w_ready, ew_rdy); end
        checks++; if (a_ready !== ea_rdy) begin failures++;
          $display("FAIL %s a_ready c=%0d got=%b exp=%b", name, c, a_ready, ea_rdy); end
        checks++; if (busy !== e_busy) begin failures++;
          $display("FAIL %s busy c=%0d got=%b exp=%b", name, c, busy, e_busy); end
        checks++; if (done !== e_done) begin failures++;
          $display("FAIL %s done c=%0d got=%b exp=%b", name, c, done, e_done); end
        checks++; if (weight_wen !== (aborted ? 1'b0 : exp_wen[c])) begin failures++;
          $display("FAIL %s weight_wen c=%0d got=%b exp=%b", name, c, weight_wen, exp_wen[c] & !aborted); end
        checks++; if (weight_din !== (aborted ? '0 : exp_wdin[c])) begin failures++;
          $display("FAIL %s weight_din c=%0d got=%h exp=%h", name, c, weight_din, aborted ? '0 : exp_wdin[c]); end
        checks++; if (data_valid !== (aborted ? 1'b0 : exp_dv[c])) begin failures++;
          $display("FAIL %s data_valid c=%0d got=%b exp=%b", name, c, data_valid, exp_dv[c] & !aborted); end
        checks++; if (operand_a !== (aborted ? '0 : exp_op[c])) begin failures++;
          $display("FAIL %s operand_a c=%0d got=%h exp=%h", name, c, operand_a, aborted ? '0 : exp_op[c]); end
        checks++; if (col_valid !== e_cv) begin failures++;
          $display("FAIL %s col_valid c=%0d got=%h exp=%h", name, c, col_valid, e_cv); end
        act_cr = '0;
        e_cr   = '0;
        for (int i = 0; i < N; i++) begin
          if (e_cv[i]) begin
            act_cr[i*CM +: CM] = col_row[i*CM +: CM];
            e_cr[i*CM +: CM]   = exp_cr[c][i*CM +: CM];
          end
        end
        checks++; if (act_cr !== e_cr) begin failures++;
          $display("FAIL %s col_row c=%0d got=%h exp=%h", name, c, act_cr, e_cr); end
      end

      if (weight_wen === 1'b1) st_wen++;
      if (data_valid === 1'b1) st_dv++;
      if (done === 1'b1) st_done_c = c;
      if (col_valid[0] === 1'b1) st_col0_rows.push_back(int'(col_row[CM-1:0]));

      if (rst_at == c) begin
        start = 1'b0; abort = 1'b0; w_valid = 1'b0; a_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({w_ready, a_ready, weight_wen, data_valid, busy, done, col_valid, col_row,
             weight_din, operand_a} !== '0) begin
          failures++;
          $display("FAIL %s async_rst_outputs c=%0d got busy=%b dv=%b cv=%h rdy=%b%b done=%b",
                   name, c, busy, data_valid, col_valid, w_ready, a_ready, done);
        end
        return;
      end
      if (done_c >= 0 && c == done_c + 2 && !aborted) return;
      if (aborted && c == abort_at + LAT + N + 2) return;

      start   = 1'b0;
      abort   = 1'b0;
      w_data  = {$urandom, $urandom, $urandom, $urandom};
      a_data  = {$urandom, $urandom, $urandom, $urandom};
      load_w  = 1'($urandom_range(1));
      m_rows  = MW'($urandom_range(63));
      if (c == 0) begin
        start  = 1'b1;
        load_w = lw;
        m_rows = MW'(mr);
      end else if (busy_starts && (c == 3 || c == done_c) && !aborted && (done_c < 0 || c <= done_c)) begin
        start = 1'b1;
      end
      w_valid = ($urandom_range(99) < wprob);
      if (ea_rdy) begin
        a_valid = (apat_len > 0) ? apat[a_ph % apat_len] : ($urandom_range(99) < aprob);
        a_ph++;
      end else begin
        a_valid = 1'($urandom_range(1));
      end
      if (abort_rows >= 0 && ea_rdy && ar == abort_rows && abort_at < 0) begin
        abort    = 1'b1;
        abort_at = c;
      end
      if (a_valid && a_ready) st_ahs++;

      if (abort_at != c && !aborted) begin
        if (ew_rdy && w_valid) begin
          exp_wen[c+1]  = 1'b1;
          exp_wdin[c+1] = w_data;
          wk++;
          if (wk == K && m_eff == 0) done_c = c + 1;
        end
        if (ea_rdy && a_valid) begin
          exp_dv[c+1] = 1'b1;
          exp_op[c+1] = a_data;
          for (int i = 0; i < N; i++) begin
            exp_cv[c+1+LAT+i][i] = 1'b1;
            exp_cr[c+1+LAT+i][i*CM +: CM] = CM'(rowi % m_eff);
          end
          rowi++;
          ar++;
          if (ar == m_eff) begin
            done_c = c + 1 + LAT + N;
            if (rst_drain) rst_at = c + 6;
          end
        end
      end
    end
    checks++;
    failures++;
    $display("FAIL %s timeout waiting for tile completion", name);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; load_w = 1'b0; m_rows = '0; abort = 1'b0;
    w_valid = 1'b0; a_valid = 1'b0; w_data = '0; a_data = '0;
    #12;
    checks++;
    if ({w_ready, a_ready, weight_wen, data_valid, busy, done, col_valid, col_row,
         weight_din, operand_a} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b dv=%b cv=%h rdy=%b%b", busy, data_valid, col_valid, w_ready, a_ready);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_reload_stream();
    run_tile(1'b1, 32, 100, 100, 32'd0, 0, -1, 1'b0, 1'b0, "reload");
    checks++; if (st_wen != K) begin failures++;
      $display("FAIL reload_wen_count got=%0d exp=%0d", st_wen, K); end
    checks++; if (st_dv != 32) begin failures++;
      $display("FAIL reload_dv_count got=%0d exp=%0d", st_dv, 32); end
    checks++; if (st_col0_rows.size() != 32) begin failures++;
      $display("FAIL reload_col0_count got=%0d exp=32", st_col0_rows.size()); end
  endtask

  task automatic test_reuse();
    run_tile(1'b0, 5, 100, 100, 32'd0, 0, -1, 1'b0, 1'b0, "reuse");
    checks++; if (st_wen != 0) begin failures++;
      $display("FAIL reuse_wen_count got=%0d exp=0", st_wen); end
    checks++; if (st_col0_rows.size() != 5) begin failures++;
      $display("FAIL reuse_col0_count got=%0d exp=5", st_col0_rows.size()); end
    for (int r = 0; r < st_col0_rows.size() && r < 5; r++) begin
      checks++; if (st_col0_rows[r] != r) begin failures++;
        $display("FAIL reuse_col0_row idx=%0d got=%0d exp=%0d", r, st_col0_rows[r], r); end
    end
  endtask

  task automatic test_bubbles();
    run_tile(1'b0, 4, 100, 100, 32'b1011001, 7, -1, 1'b0, 1'b0, "bubbles");
    checks++; if (st_dv != 4) begin failures++;
      $display("FAIL bubbles_dv_count got=%0d exp=4", st_dv); end
    for (int r = 0; r < st_col0_rows.size() && r < 4; r++) begin
      checks++; if (st_col0_rows[r] != r) begin failures++;
        $display("FAIL bubbles_col0_row idx=%0d got=%0d exp=%0d", r, st_col0_rows[r], r); end
    end
  endtask

  task automatic test_edge_counts();
    run_tile(1'b1, 0, 100, 100, 32'd0, 0, -1, 1'b0, 1'b0, "preload_only");
    checks++; if (st_wen != K || st_dv != 0) begin failures++;
      $display("FAIL preload_only_counts got wen=%0d dv=%0d exp wen=%0d dv=0", st_wen, st_dv, K); end
    run_tile(1'b0, 40, 100, 80, 32'd0, 0, -1, 1'b0, 1'b0, "clamp40");
    checks++; if (st_ahs != M_MAX) begin failures++;
      $display("FAIL clamp40_handshakes got=%0d exp=%0d", st_ahs, M_MAX); end
  endtask

  task automatic test_abort_reset();
    run_tile(1'b1, 32, 100, 70, 32'd0, 0, 10, 1'b0, 1'b0, "abort");
    checks++; if (st_done_c != -1) begin failures++;
      $display("FAIL abort_no_done got done_at=%0d exp=none", st_done_c); end
    run_tile(1'b0, 6, 100, 100, 32'd0, 0, -1, 1'b1, 1'b0, "rst_drain");
    @(posedge clk); #1 rst = 1'b0;
    run_tile(1'b0, 32, 100, 100, 32'd0, 0, -1, 1'b0, 1'b0, "after_rst");
    checks++; if (st_dv != 32 || st_done_c < 0) begin failures++;
      $display("FAIL after_rst_tile got dv=%0d done_at=%0d exp dv=32 with done", st_dv, st_done_c); end
  endtask

  task automatic test_start_while_busy();
    run_tile(1'b1, 7, 80, 80, 32'd0, 0, -1, 1'b0, 1'b1, "busy_start");
    checks++; if (st_dv != 7) begin failures++;
      $display("FAIL busy_start_dv_count got=%0d exp=7", st_dv); end
    run_tile(1'b0, 3, 100, 100, 32'd0, 0, -1, 1'b0, 1'b1, "busy_start2");
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      run_tile(1'($urandom_range(1)), $urandom_range(0, 40), $urandom_range(40, 100),
               $urandom_range(40, 100), 32'd0, 0, -1, 1'b0, 1'($urandom_range(1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_reload_stream();
    test_reuse();
    test_bubbles();
    test_edge_counts();
    test_abort_reset();
    test_start_while_busy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
